rv32i_lsu: RTL and testbench

- CPU-side load/store initiator. Converts one load/store request (byte address, size, signedness, store data) into word-aligned bus beats with byte enables.
- Its bus port drives a byte-banked word memory: word address, 4-bit lane select, write strobe, read data returned on ack.
- Lane-aligns store data; extracts, realigns and sign/zero-extends load data.
- Sits between the core's execute stage and the data memory.

---
 rtl/rv32i_lsu_if.sv | 27 ++
 rtl/rv32i_lsu.sv | 182 ++++++++++++++++++
 tb/tb_rv32i_lsu.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_lsu_if.sv
`default_nettype none
// ============================================================================
//  rv32i_lsu_if : word-banked data-memory bus between the LSU and the memory
//  Revision     : 1.0
// ============================================================================
interface rv32i_lsu_if #(
    parameter int AW = 32
) ();
    logic          mem_req;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_lsu.sv
`default_nettype none
// ============================================================================
//  rv32i_lsu : load/store unit, turns byte/half/word requests into lane-enabled
//              word beats. Define LSU_MISALIGN_EN to split misaligned accesses.
//  Revision  : 1.0
// ============================================================================
module rv32i_lsu #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [1:0]    req_sz,
    input  logic          req_uns,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [31:0]   resp_rdata,
    rv32i_lsu_if.master   mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_wr;
    logic [1:0]    r_sz;
    logic          r_uns;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [63:0]   r_rbuf;

    logic          w_accept;
    logic          w_req_err;
    logic [7:0]    w_nmask;
    logic [7:0]    w_m8;
    logic          w_split;
    logic [63:0]   w_wsh;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_next;
    logic [31:0]   w_rsh;
    logic [31:0]   w_ext;

    function automatic logic [31:0] f_lanes(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    assign w_accept = req_valid && (r_state == IDLE);

`ifdef LSU_MISALIGN_EN
    assign w_req_err = (req_sz == 2'b11);
`else
    assign w_req_err = (req_sz == 2'b11)
                    || ((req_sz == 2'b01) && req_addr[0])
                    || ((req_sz == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

    // Two-word lane window: bits [3:0] belong to the first beat, [7:4] to the next word.
    always_comb begin
        case (r_sz)
            2'b00:   w_nmask = 8'h01;
            2'b01:   w_nmask = 8'h03;
            default: w_nmask = 8'h0F;
        endcase
    end

    assign w_m8    = w_nmask << r_addr[1:0];
    assign w_split = |w_m8[7:4];
    assign w_wsh   = {32'd0, r_wdata & f_lanes(w_nmask[3:0])} << {r_addr[1:0], 3'b000};
    assign w_base  = {r_addr[AW-1:2], 2'b00};
    assign w_next  = w_base + AW'(4);
    assign w_rsh   = 32'(r_rbuf >> {r_addr[1:0], 3'b000});

    always_comb begin
        case (r_sz)
            2'b00:   w_ext = {{24{w_rsh[7]  & ~r_uns}}, w_rsh[7:0]};
            2'b01:   w_ext = {{16{w_rsh[15] & ~r_uns}}, w_rsh[15:0]};
            default: w_ext = w_rsh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_sz    <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rbuf  <= '0;
        end else begin
            if (w_accept) begin
                r_wr    <= req_wr;
                r_sz    <= req_sz;
                r_uns   <= req_uns;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_req_err;
                r_rbuf  <= '0;
            end
            if ((r_state == BEAT0) && mem.mem_ack) begin
                r_rbuf[31:0] <= mem.mem_rdata & f_lanes(w_m8[3:0]);
            end
            if ((r_state == BEAT1) && mem.mem_ack) begin
                r_rbuf[63:32] <= mem.mem_rdata & f_lanes(w_m8[7:4]);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        resp_rdata    = 32'd0;
        mem.mem_req   = 1'b0;
        mem.mem_wr    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_be    = 4'b0000;
        mem.mem_wdata = 32'd0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_req_err ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                mem.mem_req   = 1'b1;
                mem.mem_wr    = r_wr;
                mem.mem_addr  = w_base;
                mem.mem_be    = w_m8[3:0];
                mem.mem_wdata = w_wsh[31:0];
                if (mem.mem_ack) begin
                    w_state_nxt = w_split ? BEAT1 : RESP;
                end
            end
            BEAT1: begin
                mem.mem_req   = 1'b1;
                mem.mem_wr    = r_wr;
                mem.mem_addr  = w_next;
                mem.mem_be    = w_m8[7:4];
                mem.mem_wdata = w_wsh[63:32];
                if (mem.mem_ack) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid  = 1'b1;
                resp_err    = r_err;
                resp_rdata  = (r_err || r_wr) ? 32'd0 : w_ext;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_lsu.sv
`default_nettype none
// ============================================================================
//  tb_rv32i_lsu : random and directed load/store traffic against a byte-level
//                 memory model and a wait-state-injecting bus responder.
//  Revision     : 1.0
// ============================================================================
module tb_rv32i_lsu;
    localparam int AW = 32;
`ifdef LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_wr, req_uns;
    logic [1:0]  req_sz;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    rv32i_lsu_if #(.AW(AW)) bus ();

    rv32i_lsu #(.AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_sz     (req_sz),
        .req_uns    (req_uns),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem        (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wr;
    } beat_t;

    beat_t       log_q[$];
    logic [31:0] bus_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : 32'h0;
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h0;
    endfunction

    task automatic init_byte(input logic [31:0] a, input logic [7:0] v);
        logic [31:0] w;
        ref_mem[a] = v;
        w = rd_word({a[31:2], 2'b00});
        w[8*a[1:0] +: 8] = v;
        bus_mem[{a[31:2], 2'b00}] = w;
    endtask

    // Bus responder: random or forced wait states, word memory, beat log.
    bit          resp_en = 1'b1;
    int          wait_left = -1;
    int          force_wait = -1;
    int          max_wait = 0;
    int          waits_sum = 0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                if (bus.mem_req) begin
                    if (wait_left < 0) begin
                        wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, max_wait));
                        waits_sum += wait_left;
                        s_addr  = bus.mem_addr;
                        s_be    = bus.mem_be;
                        s_wdata = bus.mem_wdata;
                    end else begin
                        check_eq("hold_addr", bus.mem_addr, s_addr);
                        check_eq("hold_be", {28'd0, bus.mem_be}, {28'd0, s_be});
                        check_eq("hold_wdata", bus.mem_wdata, s_wdata);
                        check_eq("busy_ready", {31'd0, req_ready}, 32'd0);
                    end
                    if (wait_left == 0) begin
                        beat_t b;
                        logic [31:0] w;
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = rd_word(bus.mem_addr);
                        b.addr  = bus.mem_addr;
                        b.be    = bus.mem_be;
                        b.wdata = bus.mem_wdata;
                        b.wr    = bus.mem_wr;
                        log_q.push_back(b);
                        if (bus.mem_wr) begin
                            w = rd_word(bus.mem_addr);
                            for (int l = 0; l < 4; l++) begin
                                if (bus.mem_be[l]) w[8*l +: 8] = bus.mem_wdata[8*l +: 8];
                            end
                            bus_mem[bus.mem_addr] = w;
                        end
                        wait_left = -1;
                    end else begin
                        wait_left--;
                    end
                end
            end else begin
                wait_left = -1;
            end
        end
    end

    // One request; expectations derived byte-by-byte from the access rules.
    task automatic access(input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int          n, ne, k, cyc, lane;
        bit          exp_err, done;
        logic [31:0] exp_rd, a, wa, ones;
        logic [31:0] e_addr [2];
        logic [3:0]  e_be [2];
        logic [31:0] e_wd [2];
        n       = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_err = (sz == 2'b11) || ((((addr & (n - 1)) != 0)) && !MIS);
        exp_rd  = 32'h0;
        ne      = 0;
        ones    = 32'hFFFF_FFFF;
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                a    = addr + i;
                wa   = {a[31:2], 2'b00};
                lane = int'(a[1:0]);
                k    = -1;
                for (int j = 0; j < ne; j++) if (e_addr[j] == wa) k = j;
                if (k < 0) begin
                    k = ne;
                    e_addr[k] = wa;
                    e_be[k]   = 4'b0;
                    e_wd[k]   = 32'h0;
                    ne++;
                end
                e_be[k][lane] = 1'b1;
                if (wr) begin
                    e_wd[k][8*lane +: 8] = wd[8*i +: 8];
                    ref_mem[a] = wd[8*i +: 8];
                end else begin
                    exp_rd = exp_rd | ({24'd0, rd_ref(a)} << (8*i));
                end
            end
            if (wr) exp_rd = 32'h0;
            else if (!uns && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (ones << (8*n));
        end

        log_q.delete();
        waits_sum = 0;
        check_eq("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_sz    = sz;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_eq("first_mem_req", {31'd0, bus.mem_req}, {31'd0, !exp_err});
            if (resp_valid) done = 1'b1;
        end
        check_eq("resp_seen", {31'd0, done}, 32'd1);
        rd = resp_rdata;
        er = resp_err;
        if (done) begin
            check_eq("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
            check_eq("resp_rdata", resp_rdata, exp_rd);
            check_eq("latency", cyc, 1 + ne + waits_sum);
            check_eq("beat_count", log_q.size(), ne);
            for (int j = 0; j < ne && j < log_q.size(); j++) begin
                check_eq("beat_addr", log_q[j].addr, e_addr[j]);
                check_eq("beat_be", {28'd0, log_q[j].be}, {28'd0, e_be[j]});
                check_eq("beat_wr", {31'd0, log_q[j].wr}, {31'd0, wr});
                if (wr) check_eq("beat_wdata", log_q[j].wdata, e_wd[j]);
            end
            @(negedge clk);
            check_eq("resp_pulse", {31'd0, resp_valid}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_sz    = 2'b10;
        req_uns   = 1'b0;
        req_addr  = 32'h100;
        req_wdata = 32'h0;
        for (int i = 0; i < 96; i++) begin
            init_byte(32'hF0 + i, 8'($urandom));
            init_byte(32'hFFFF_FFF0 + i, 8'($urandom));
        end

        // Reset with a request pending: must be ignored, outputs cleared.
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("post_rst_no_req", {31'd0, bus.mem_req}, 32'd0);

        // Aligned store / load.
        access(1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344, rd, er);
        if (log_q.size() == 1) begin
            check_eq("sw_addr", log_q[0].addr, 32'h100);
            check_eq("sw_be", {28'd0, log_q[0].be}, 32'hF);
            check_eq("sw_wdata", log_q[0].wdata, 32'h1122_3344);
        end
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er);
        check_eq("lw_val", rd, 32'h1122_3344);

        // Byte / half extension.
        access(1'b1, 2'b10, 1'b0, 32'h100, 32'h8877_6655, rd, er);
        access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, rd, er);
        check_eq("lb_val", rd, 32'hFFFF_FF88);
        access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, rd, er);
        check_eq("lbu_val", rd, 32'h0000_0088);
        access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, rd, er);
        check_eq("lh_val", rd, 32'hFFFF_8877);
        if (log_q.size() == 1) check_eq("lh_be", {28'd0, log_q[0].be}, 32'hC);
        access(1'b1, 2'b00, 1'b0, 32'h101, 32'hFFFF_FFAB, rd, er);
        if (log_q.size() == 1) begin
            check_eq("sb_be", {28'd0, log_q[0].be}, 32'h2);
            check_eq("sb_wdata", log_q[0].wdata, 32'h0000_AB00);
        end

        // Five wait states.
        force_wait = 5;
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er);
        force_wait = -1;

`ifdef LSU_MISALIGN_EN
        access(1'b1, 2'b10, 1'b0, 32'h103, 32'h1122_3344, rd, er);
        if (log_q.size() == 2) begin
            check_eq("msw_a0", log_q[0].addr, 32'h100);
            check_eq("msw_be0", {28'd0, log_q[0].be}, 32'h8);
            check_eq("msw_wd0", log_q[0].wdata, 32'h4400_0000);
            check_eq("msw_a1", log_q[1].addr, 32'h104);
            check_eq("msw_be1", {28'd0, log_q[1].be}, 32'h7);
            check_eq("msw_wd1", log_q[1].wdata, 32'h0011_2233);
        end
        access(1'b1, 2'b10, 1'b0, 32'h100, 32'h8877_6655, rd, er);
        access(1'b1, 2'b10, 1'b0, 32'h104, 32'hDDCC_BBAA, rd, er);
        access(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, rd, er);
        check_eq("mlh_val", rd, 32'hFFFF_AA88);
        access(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, rd, er);
        if (log_q.size() == 1) check_eq("mlh_be", {28'd0, log_q[0].be}, 32'h6);
        access(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, rd, er);
        if (log_q.size() == 2) check_eq("wrap_a1", log_q[1].addr, 32'h0);
`else
        access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, er);
        check_eq("mis_err", {31'd0, er}, 32'd1);
        check_eq("mis_rdata", rd, 32'h0);
        check_eq("mis_beats", log_q.size(), 0);
`endif
        access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd, er);
        check_eq("sz11_err", {31'd0, er}, 32'd1);
        check_eq("sz11_beats", log_q.size(), 0);

        // Reset while BEAT0 is outstanding.
        resp_en   = 1'b0;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_sz    = 2'b10;
        req_addr  = 32'h100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_beat_req", {31'd0, bus.mem_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("abort_resp", {31'd0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("late_ack_req", {31'd0, bus.mem_req}, 32'd0);
            check_eq("late_ack_resp", {31'd0, resp_valid}, 32'd0);
            check_eq("late_ack_ready", {31'd0, req_ready}, 32'd1);
        end
        bus.mem_ack = 1'b0;
        resp_en = 1'b1;
        access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, rd, er);

        // Random traffic with random wait states.
        max_wait = 3;
        for (int t = 0; t < 300; t++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   32'h100 + $urandom_range(0, 63), $urandom, rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
